// File: rtl/intra_pkg.sv
// Shared types and width helpers for the 4x4 luma intra mode selector.
package intra_pkg;

    typedef enum logic [1:0] {
        INTRA4_V  = 2'd0,
        INTRA4_H  = 2'd1,
        INTRA4_DC = 2'd2
    } intra_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int BIT_DEPTH_DEF = 8;
    localparam int SAD_W         = BIT_DEPTH_DEF + 4;
    localparam int RES_W         = BIT_DEPTH_DEF + 1;

    function automatic int sad_width(input int bd);
        return bd + 4;
    endfunction

    function automatic int res_width(input int bd);
        return bd + 1;
    endfunction

endpackage

// File: rtl/intra_4x4_pred_gen.sv
// Combinational 4x4 V/H/DC predictor from latched neighbours and availability flags.
module intra_4x4_pred_gen
    import intra_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic [1:0]                       mode,
    input  logic [3:0][BIT_DEPTH-1:0]        top,
    input  logic [3:0][BIT_DEPTH-1:0]        left,
    input  logic                             avail_a,
    input  logic                             avail_b,
    output logic [3:0][3:0][BIT_DEPTH-1:0]   pred
);

    localparam int SUM_W = BIT_DEPTH + 3;

    logic [SUM_W-1:0]     sum_t;
    logic [SUM_W-1:0]     sum_l;
    logic [BIT_DEPTH-1:0] dc;

    always_comb begin
        sum_t = '0;
        sum_l = '0;
        for (int k = 0; k < 4; k++) begin
            sum_t = sum_t + SUM_W'(top[k]);
            sum_l = sum_l + SUM_W'(left[k]);
        end
        if (avail_a && avail_b)
            dc = BIT_DEPTH'((sum_t + sum_l + SUM_W'(4)) >> 3);
        else if (avail_b)
            dc = BIT_DEPTH'((sum_t + SUM_W'(2)) >> 2);
        else if (avail_a)
            dc = BIT_DEPTH'((sum_l + SUM_W'(2)) >> 2);
        else
            dc = BIT_DEPTH'(1 << (BIT_DEPTH - 1));
    end

    always_comb begin
        pred = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (mode)
                    INTRA4_V: pred[i][j] = top[j];
                    INTRA4_H: pred[i][j] = left[i];
                    default:  pred[i][j] = dc;
                endcase
            end
        end
    end

endmodule

// File: rtl/intra_4x4_mode_sel.sv
// Sequential 4x4 intra mode decision: one candidate per cycle, minimum SAD wins, ties keep lower mode.
module intra_4x4_mode_sel
    import intra_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int EN_VH     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [3:0][BIT_DEPTH-1:0]        top,
    input  logic [3:0][BIT_DEPTH-1:0]        left,
    input  logic                             mbAddrA_valid,
    input  logic                             mbAddrB_valid,
    input  logic [3:0][3:0][BIT_DEPTH-1:0]   orig,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [1:0]                       best_mode,
    output logic [BIT_DEPTH+3:0]             best_sad,
    output logic [3:0][3:0][BIT_DEPTH-1:0]   pred_matrix,
    output logic [3:0][3:0][BIT_DEPTH:0]     residual
);

    localparam int SW = sad_width(BIT_DEPTH);
    localparam int RW = res_width(BIT_DEPTH);

    state_e                           state, state_nxt;
    logic [3:0][BIT_DEPTH-1:0]        top_q, left_q;
    logic                             a_q, b_q;
    logic [3:0][3:0][BIT_DEPTH-1:0]   orig_q;
    logic [1:0]                       mode_q, best_mode_q;
    logic [SW-1:0]                    best_sad_q;
    logic                             have_best_q;

    logic [3:0][3:0][BIT_DEPTH-1:0]   cand_pred, win_pred;
    logic [3:0][3:0][RW-1:0]          cand_diff;
    logic [3:0][3:0][BIT_DEPTH-1:0]   cand_abs;
    logic [SW-1:0]                    cand_sad;
    logic                             cand_avail, cand_take;

    intra_4x4_pred_gen #(.BIT_DEPTH(BIT_DEPTH)) u_pred_cand (
        .mode(mode_q), .top(top_q), .left(left_q),
        .avail_a(a_q), .avail_b(b_q), .pred(cand_pred)
    );

    intra_4x4_pred_gen #(.BIT_DEPTH(BIT_DEPTH)) u_pred_win (
        .mode(best_mode_q), .top(top_q), .left(left_q),
        .avail_a(a_q), .avail_b(b_q), .pred(win_pred)
    );

    always_comb begin
        cand_sad = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                cand_diff[i][j] = {1'b0, orig_q[i][j]} - {1'b0, cand_pred[i][j]};
                cand_abs[i][j]  = cand_diff[i][j][BIT_DEPTH] ? BIT_DEPTH'(-cand_diff[i][j])
                                                             : cand_diff[i][j][BIT_DEPTH-1:0];
                cand_sad        = cand_sad + SW'(cand_abs[i][j]);
            end
        end
    end

    // Unavailable candidates burn their cycle but can never become best.
    always_comb begin
        case (mode_q)
            INTRA4_V: cand_avail = b_q;
            INTRA4_H: cand_avail = a_q;
            default:  cand_avail = 1'b1;
        endcase
        cand_take = cand_avail && (!have_best_q || (cand_sad < best_sad_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_EVAL;
            ST_EVAL: if (mode_q == INTRA4_DC) state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q       <= '0;
            left_q      <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            orig_q      <= '0;
            mode_q      <= INTRA4_DC;
            best_mode_q <= INTRA4_DC;
            best_sad_q  <= '0;
            have_best_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && in_valid) begin
                top_q       <= top;
                left_q      <= left;
                a_q         <= mbAddrA_valid;
                b_q         <= mbAddrB_valid;
                orig_q      <= orig;
                mode_q      <= (EN_VH != 0) ? INTRA4_V : INTRA4_DC;
                have_best_q <= 1'b0;
            end
            if (state == ST_EVAL) begin
                if (cand_take) begin
                    best_mode_q <= mode_q;
                    best_sad_q  <= cand_sad;
                    have_best_q <= 1'b1;
                end
                if (mode_q != INTRA4_DC) mode_q <= mode_q + 2'd1;
            end
        end
    end

    always_comb begin
        best_mode   = best_mode_q;
        best_sad    = best_sad_q;
        pred_matrix = '0;
        residual    = '0;
        if (out_valid) begin
            pred_matrix = win_pred;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    residual[i][j] = {1'b0, orig_q[i][j]} - {1'b0, win_pred[i][j]};
        end
    end

endmodule

// File: tb/tb_intra_4x4_mode_sel.sv
// Directed scoreboard bench for intra_4x4_mode_sel, covering the V/H/DC and DC-only builds.
module tb_intra_4x4_mode_sel;

    typedef logic [3:0][7:0]       row_t;
    typedef logic [3:0][3:0][7:0]  blk_t;
    typedef logic [3:0][3:0][8:0]  res_t;
    typedef struct {
        logic [1:0]  mode;
        logic [11:0] sad;
        blk_t        pred;
        res_t        res;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready, sel;
    row_t top_i, left_i;
    logic a_i, b_i;
    blk_t orig_i;

    logic        v_in_ready, v_out_valid, d_in_ready, d_out_valid;
    logic [1:0]  v_mode, d_mode;
    logic [11:0] v_sad, d_sad;
    blk_t        v_pred, d_pred;
    res_t        v_res, d_res;

    logic        m_in_ready, m_out_valid;
    logic [1:0]  m_mode;
    logic [11:0] m_sad;
    blk_t        m_pred;
    res_t        m_res;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    intra_4x4_mode_sel #(.BIT_DEPTH(8), .EN_VH(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(v_in_ready),
        .top(top_i), .left(left_i), .mbAddrA_valid(a_i), .mbAddrB_valid(b_i),
        .orig(orig_i), .out_valid(v_out_valid), .out_ready(out_ready & ~sel),
        .best_mode(v_mode), .best_sad(v_sad), .pred_matrix(v_pred), .residual(v_res)
    );

    intra_4x4_mode_sel #(.BIT_DEPTH(8), .EN_VH(0)) dut_dc (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(d_in_ready),
        .top(top_i), .left(left_i), .mbAddrA_valid(a_i), .mbAddrB_valid(b_i),
        .orig(orig_i), .out_valid(d_out_valid), .out_ready(out_ready & sel),
        .best_mode(d_mode), .best_sad(d_sad), .pred_matrix(d_pred), .residual(d_res)
    );

    assign m_in_ready  = sel ? d_in_ready  : v_in_ready;
    assign m_out_valid = sel ? d_out_valid : v_out_valid;
    assign m_mode      = sel ? d_mode      : v_mode;
    assign m_sad       = sel ? d_sad       : v_sad;
    assign m_pred      = sel ? d_pred      : v_pred;
    assign m_res       = sel ? d_res       : v_res;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input row_t t, input row_t l, input bit a, input bit b,
                                   input blk_t o, input bit en_vh);
        exp_t r, c;
        bit   have, av;
        int   s_t, s_l, dc, p, d, sad;
        have = 0;
        s_t = 0;
        s_l = 0;
        for (int k = 0; k < 4; k++) begin
            s_t += int'(t[k]);
            s_l += int'(l[k]);
        end
        if (a && b)  dc = (s_t + s_l + 4) >> 3;
        else if (b)  dc = (s_t + 2) >> 2;
        else if (a)  dc = (s_l + 2) >> 2;
        else         dc = 128;
        r.mode = 2'd2; r.sad = '0; r.pred = '0; r.res = '0;
        for (int m = (en_vh ? 0 : 2); m < 3; m++) begin
            av  = (m == 0) ? b : (m == 1) ? a : 1'b1;
            sad = 0;
            c.mode = 2'(m);
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    p = (m == 0) ? int'(t[j]) : (m == 1) ? int'(l[i]) : dc;
                    d = int'(o[i][j]) - p;
                    c.pred[i][j] = 8'(p);
                    c.res[i][j]  = 9'(d);
                    sad += (d < 0) ? -d : d;
                end
            end
            c.sad = 12'(sad);
            if (av && (!have || sad < int'(r.sad))) begin
                r    = c;
                have = 1;
            end
        end
        return r;
    endfunction

    task automatic send(input bit push_exp);
        int n = 0;
        while (!m_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", m_in_ready, 1'b1);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (push_exp) sb.push_back(model(top_i, left_i, a_i, b_i, orig_i, !sel));
    endtask

    task automatic receive(input int exp_lat, input int hold);
        exp_t e;
        int   lat = 0;
        while (!m_out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, exp_lat);
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: observed 0 entries required 1");
            $fatal(1, "scoreboard underflow");
        end
        e = sb.pop_front();
        for (int k = 0; k <= hold; k++) begin
            chk("out_valid",   m_out_valid, 1'b1);
            chk("in_ready_lo", m_in_ready,  1'b0);
            chk("best_mode",   m_mode,      e.mode);
            chk("best_sad",    m_sad,       e.sad);
            chk("pred_matrix", m_pred,      e.pred);
            chk("residual",    m_res,       e.res);
            if (k < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_pop", m_out_valid, 1'b0);
        chk("in_ready_after_pop",  m_in_ready,  1'b1);
        chk("pred_zero_idle",      m_pred,      '0);
        chk("residual_zero_idle",  m_res,       '0);
    endtask

    task automatic set_block(input row_t t, input row_t l, input bit a, input bit b, input blk_t o);
        top_i = t; left_i = l; a_i = a; b_i = b; orig_i = o;
    endtask

    initial begin
        row_t t, l;
        blk_t o;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
        top_i = '0; left_i = '0; a_i = 1'b0; b_i = 1'b0; orig_i = '0;

        @(negedge clk);
        chk("rst_in_ready",  v_in_ready,  1'b1);
        chk("rst_out_valid", v_out_valid, 1'b0);
        chk("rst_best_mode", v_mode,      2'd2);
        chk("rst_best_sad",  v_sad,       12'd0);
        chk("rst_pred",      v_pred,      '0);
        chk("rst_residual",  v_res,       '0);
        chk("rst_dc_ready",  d_in_ready,  1'b1);
        rst = 1'b0;
        @(negedge clk);

        // No neighbours, flat mid-grey block.
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) o[i][j] = 8'd128;
        set_block('0, '0, 1'b0, 1'b0, o);
        send(1); receive(3, 0);

        // Vertical-perfect block.
        t[0] = 8'd10; t[1] = 8'd20; t[2] = 8'd30; t[3] = 8'd40;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) o[i][j] = t[j];
        set_block(t, '0, 1'b1, 1'b1, o);
        send(1); receive(3, 0);

        // Horizontal-perfect block, top unavailable.
        l[0] = 8'd5; l[1] = 8'd50; l[2] = 8'd100; l[3] = 8'd200;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) o[i][j] = l[i];
        set_block('0, l, 1'b1, 1'b0, o);
        send(1); receive(3, 0);

        // Three-way tie at SAD 0.
        for (int k = 0; k < 4; k++) begin t[k] = 8'd100; l[k] = 8'd100; end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) o[i][j] = 8'd100;
        set_block(t, l, 1'b1, 1'b1, o);
        send(1); receive(3, 0);

        // Maximum negative residual with held output.
        for (int k = 0; k < 4; k++) t[k] = 8'd255;
        set_block(t, '0, 1'b0, 1'b1, '0);
        send(1); receive(3, 5);

        // Reset while evaluating.
        set_block(t, '0, 1'b0, 1'b1, '0);
        send(0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", v_out_valid, 1'b0);
        chk("midrst_in_ready",  v_in_ready,  1'b1);
        chk("midrst_best_mode", v_mode,      2'd2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        t[0] = 8'd10; t[1] = 8'd20; t[2] = 8'd30; t[3] = 8'd40;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) o[i][j] = t[j];
        set_block(t, '0, 1'b1, 1'b1, o);
        send(1); receive(3, 0);

        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 4; k++) begin
                t[k] = 8'($urandom_range(0, 255));
                l[k] = 8'($urandom_range(0, 255));
            end
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) o[i][j] = 8'($urandom_range(0, 255));
            set_block(t, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
            send(1); receive(3, 0);
        end

        // DC-only build.
        sel = 1'b1;
        @(negedge clk);
        t[0] = 8'd10; t[1] = 8'd20; t[2] = 8'd30; t[3] = 8'd40;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) o[i][j] = t[j];
        set_block(t, '0, 1'b1, 1'b1, o);
        send(1); receive(1, 0);

        for (int k = 0; k < 4; k++) t[k] = 8'd255;
        set_block(t, '0, 1'b0, 1'b1, '0);
        send(1); receive(1, 5);

        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) o[i][j] = 8'd128;
        set_block('0, '0, 1'b0, 1'b0, o);
        send(1); receive(1, 0);

        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 4; k++) begin
                t[k] = 8'($urandom_range(0, 255));
                l[k] = 8'($urandom_range(0, 255));
            end
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) o[i][j] = 8'($urandom_range(0, 255));
            set_block(t, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
            send(1); receive(1, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
